// File: rtl/speed_computation_mc.sv
// rtl/speed_computation_mc.sv - multi-channel period-count to fixed-point speed converter
//
// Converts per-channel period counts into floor(K_CONST * 2^OUT_FRAC / cnt) using
// one shared radix-2 restoring divider, served round-robin across channels.
// Optional feature macro: SPEED_COMP_ROUND_EN (round-to-nearest instead of floor).
//
// Ports:
//   clk_1        in   clock
//   clr_n_1      in   asynchronous reset, active low
//   ce_1         in   clock enable; all state advances only when high
//   cnt_valid    in   [NUM_CH] per-channel new-sample strobe
//   speed_cnt    in   [NUM_CH*CNT_WIDTH] packed counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   overrun_clr  in   [NUM_CH] clears overrun bits
//   speed_rpm    out  [OUT_WIDTH] signed result, OUT_FRAC fractional bits
//   rpm_valid    out  result strobe, one ce-qualified cycle
//   rpm_ch       out  channel of the current result
//   rpm_sat      out  result was saturated
//   rpm_zero     out  input count was zero
//   overrun      out  [NUM_CH] sticky per-channel overwrite flag
module speed_computation_mc #(
    parameter int              NUM_CH    = 4,
    parameter int              CNT_WIDTH = 32,
    parameter int              K_WIDTH   = 32,
    parameter longint unsigned K_CONST   = 60000000,
    parameter int              OUT_WIDTH = 32,
    parameter int              OUT_FRAC  = 16,
    localparam int             CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk_1,
    input  logic                          clr_n_1,
    input  logic                          ce_1,
    input  logic [NUM_CH-1:0]             cnt_valid,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   speed_cnt,
    input  logic [NUM_CH-1:0]             overrun_clr,
    output logic [OUT_WIDTH-1:0]          speed_rpm,
    output logic                          rpm_valid,
    output logic [CH_W-1:0]               rpm_ch,
    output logic                          rpm_sat,
    output logic                          rpm_zero,
    output logic [NUM_CH-1:0]             overrun
);
    localparam int DW = K_WIDTH + OUT_FRAC;
    localparam int IW = $clog2(DW) + 1;
    localparam int QW = DW + 1;
    localparam int CW = (QW > OUT_WIDTH) ? QW : OUT_WIDTH;
    localparam logic [K_WIDTH-1:0] K_VEC    = K_WIDTH'(K_CONST);
    localparam logic [DW-1:0]      DIVIDEND = {K_VEC, {OUT_FRAC{1'b0}}};
    localparam logic [CW-1:0]      SAT_MAX  = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_OUT} state_t;

    state_t                r_state;
    logic [NUM_CH-1:0]     r_pend;
    logic [CNT_WIDTH-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0]     r_overrun;
    logic [CH_W-1:0]       r_last;
    logic [CH_W-1:0]       r_cur;
    logic [CNT_WIDTH-1:0]  r_div_cnt;
    logic [DW-1:0]         r_dq;        // dividend bits shift out the top, quotient bits shift in the bottom
    logic [CNT_WIDTH-1:0]  r_rem;
    logic [IW-1:0]         r_iter;
    logic                  r_zero_job;
    logic [OUT_WIDTH-1:0]  r_speed;
    logic                  r_valid;
    logic [CH_W-1:0]       r_ch;
    logic                  r_sat;
    logic                  r_zero;

    logic                  w_found;
    logic [CH_W-1:0]       w_pick;
    logic                  w_capture;
    logic [CNT_WIDTH:0]    w_rem_sh;
    logic                  w_ge;
    logic [CNT_WIDTH:0]    w_rem_nx;
    logic                  w_round;
    logic [CW-1:0]         w_q;
    logic                  w_sat;
    logic [OUT_WIDTH-1:0]  w_res;

    // Round-robin: scan from the channel after last-served; descending scan so the
    // nearest pending channel is the one left assigned.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (r_pend[(int'(r_last) + k) % NUM_CH]) begin
                w_found = 1'b1;
                w_pick  = CH_W'((int'(r_last) + k) % NUM_CH);
            end
        end
    end

    assign w_capture = ce_1 && (r_state == S_IDLE) && w_found;

    assign w_rem_sh = {r_rem, r_dq[DW-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div_cnt});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div_cnt}) : w_rem_sh;

`ifdef SPEED_COMP_ROUND_EN
    assign w_round = ({r_rem, 1'b0} >= {1'b0, r_div_cnt});
`else
    assign w_round = 1'b0;
`endif

    // Saturation is judged on the (possibly rounded) quotient.
    assign w_q   = CW'(r_dq) + CW'(w_round);
    assign w_sat = (w_q > SAT_MAX);
    assign w_res = w_sat ? SAT_MAX[OUT_WIDTH-1:0] : w_q[OUT_WIDTH-1:0];

    always_ff @(posedge clk_1 or negedge clr_n_1) begin
        if (!clr_n_1) begin
            r_pend    <= '0;
            r_overrun <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else if (ce_1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A new sample on the channel being captured re-arms pending without
                // counting as an overwrite: the old sample was consumed, not lost.
                if (cnt_valid[i]) begin
                    r_cnt[i]  <= speed_cnt[i*CNT_WIDTH +: CNT_WIDTH];
                    r_pend[i] <= 1'b1;
                end else if (w_capture && (w_pick == CH_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
                if (cnt_valid[i] && r_pend[i] && !(w_capture && (w_pick == CH_W'(i))))
                    r_overrun[i] <= 1'b1;
                else if (overrun_clr[i])
                    r_overrun[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_1 or negedge clr_n_1) begin
        if (!clr_n_1) begin
            r_state    <= S_IDLE;
            r_last     <= CH_W'(NUM_CH - 1);
            r_cur      <= '0;
            r_div_cnt  <= '0;
            r_dq       <= '0;
            r_rem      <= '0;
            r_iter     <= '0;
            r_zero_job <= 1'b0;
            r_speed    <= '0;
            r_valid    <= 1'b0;
            r_ch       <= '0;
            r_sat      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (ce_1) begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cur     <= w_pick;
                        r_div_cnt <= r_cnt[w_pick];
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rem  <= '0;
                    r_dq   <= DIVIDEND;
                    r_iter <= IW'(DW - 1);
                    if (r_div_cnt == '0) begin
                        r_zero_job <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_zero_job <= 1'b0;
                        r_state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nx[CNT_WIDTH-1:0];
                    r_dq   <= {r_dq[DW-2:0], w_ge};
                    r_iter <= r_iter - IW'(1);
                    if (r_iter == '0) r_state <= S_OUT;
                end
                default: begin
                    r_valid <= 1'b1;
                    r_ch    <= r_cur;
                    r_last  <= r_cur;
                    if (r_zero_job) begin
                        r_speed <= '0;
                        r_sat   <= 1'b0;
                        r_zero  <= 1'b1;
                    end else begin
                        r_speed <= w_res;
                        r_sat   <= w_sat;
                        r_zero  <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign speed_rpm = r_speed;
    assign rpm_valid = r_valid;
    assign rpm_ch    = r_ch;
    assign rpm_sat   = r_sat;
    assign rpm_zero  = r_zero;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_speed_computation_mc.sv
// tb/tb_speed_computation_mc.sv - self-checking bench for speed_computation_mc
module tb_speed_computation_mc;

    typedef struct {
        int          ch;
        logic [31:0] val;
        logic        sat;
        logic        zero;
        int          at;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         ce = 1'b0;
    logic [3:0]   cnt_valid = '0;
    logic [127:0] speed_cnt = '0;
    logic [3:0]   overrun_clr = '0;

    logic [31:0]  spd  [3];
    logic         vld  [3];
    logic [1:0]   chn  [3];
    logic         sat  [3];
    logic         zro  [3];
    logic [3:0]   ovr  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_pass = 0;
    int n_total = 0;
    int ce_edges = 0;

    always #5 clk = ~clk;

    speed_computation_mc #(.K_CONST(60)) u0 (
        .clk_1(clk), .clr_n_1(clr_n), .ce_1(ce), .cnt_valid(cnt_valid), .speed_cnt(speed_cnt),
        .overrun_clr(overrun_clr), .speed_rpm(spd[0]), .rpm_valid(vld[0]), .rpm_ch(chn[0]),
        .rpm_sat(sat[0]), .rpm_zero(zro[0]), .overrun(ovr[0]));
    speed_computation_mc #(.K_CONST(2)) u1 (
        .clk_1(clk), .clr_n_1(clr_n), .ce_1(ce), .cnt_valid(cnt_valid), .speed_cnt(speed_cnt),
        .overrun_clr(overrun_clr), .speed_rpm(spd[1]), .rpm_valid(vld[1]), .rpm_ch(chn[1]),
        .rpm_sat(sat[1]), .rpm_zero(zro[1]), .overrun(ovr[1]));
    speed_computation_mc #(.K_CONST(60000)) u2 (
        .clk_1(clk), .clr_n_1(clr_n), .ce_1(ce), .cnt_valid(cnt_valid), .speed_cnt(speed_cnt),
        .overrun_clr(overrun_clr), .speed_rpm(spd[2]), .rpm_valid(vld[2]), .rpm_ch(chn[2]),
        .rpm_sat(sat[2]), .rpm_zero(zro[2]), .overrun(ovr[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act !== expv)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        else
            n_pass++;
    endtask

    function automatic longint unsigned kval(input int k);
        case (k)
            0: return 60;
            1: return 2;
            default: return 60000;
        endcase
    endfunction

    // Reference: floor (or nearest) of K * 2^16 / cnt, clipped to the positive int32 range.
    function automatic exp_t model(input int k, input int ch, input logic [31:0] cnt, input int at);
        exp_t e;
        longint unsigned qq, rr;
        e.ch = ch; e.at = at; e.sat = 1'b0; e.zero = 1'b0; e.val = '0;
        if (cnt == 0) begin
            e.zero = 1'b1;
        end else begin
            qq = (kval(k) << 16) / longint'(cnt);
            rr = (kval(k) << 16) % longint'(cnt);
`ifdef SPEED_COMP_ROUND_EN
            if (2 * rr >= longint'(cnt)) qq = qq + 1;
`else
            if (rr > 0) qq = qq + 0;
`endif
            if (qq > 64'h7FFF_FFFF) begin
                e.val = 32'h7FFF_FFFF;
                e.sat = 1'b1;
            end else begin
                e.val = qq[31:0];
            end
        end
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_model(input int k, input int ch, input logic [31:0] cnt, input int at);
        push(k, model(k, ch, cnt, at));
    endtask

    task automatic push_lit(input int k, input int ch, input logic [31:0] val, input logic s,
                            input logic z, input int at);
        exp_t e;
        e.ch = ch; e.val = val; e.sat = s; e.zero = z; e.at = at;
        push(k, e);
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        int sz;
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            chk($sformatf("u%0d_unexpected_valid", k), 64'd1, 64'd0);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("u%0d_speed_rpm", k), 64'(spd[k]), 64'(e.val));
            chk($sformatf("u%0d_rpm_ch", k), 64'(chn[k]), 64'(e.ch));
            chk($sformatf("u%0d_rpm_sat", k), 64'(sat[k]), 64'(e.sat));
            chk($sformatf("u%0d_rpm_zero", k), 64'(zro[k]), 64'(e.zero));
            if (e.at >= 0)
                chk($sformatf("u%0d_latency_edge", k), 64'(ce_edges), 64'(e.at));
        end
    endtask

    always @(posedge clk) if (ce) ce_edges++;

    // Every ce-qualified edge that leaves rpm_valid high is a fresh result.
    always @(posedge clk) begin
        logic ce_s;
        ce_s = ce;
        #1;
        if (ce_s && clr_n) begin
            for (int k = 0; k < 3; k++)
                if (vld[k]) pop_check(k);
        end
    end

    task automatic check_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_u%0d_speed_rpm", tag, k), 64'(spd[k]), 64'd0);
            chk($sformatf("%s_u%0d_rpm_valid", tag, k), 64'(vld[k]), 64'd0);
            chk($sformatf("%s_u%0d_rpm_ch", tag, k), 64'(chn[k]), 64'd0);
            chk($sformatf("%s_u%0d_rpm_sat", tag, k), 64'(sat[k]), 64'd0);
            chk($sformatf("%s_u%0d_rpm_zero", tag, k), 64'(zro[k]), 64'd0);
            chk($sformatf("%s_u%0d_overrun", tag, k), 64'(ovr[k]), 64'd0);
        end
    endtask

    task automatic strobe(input logic [3:0] m, input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] c3, output int s);
        @(negedge clk);
        cnt_valid = m;
        speed_cnt = {c3, c2, c1, c0};
        @(negedge clk);
        cnt_valid = '0;
        s = ce_edges;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_results_outstanding", tag), 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    initial begin
        int s;
        clr_n = 1'b0;
        ce = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        clr_n = 1'b1;
        @(negedge clk);

        // All four channels at once, served ch0..ch3 from reset.
        strobe(4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, s);
        push_lit(0, 0, 32'h003C_0000, 1'b0, 1'b0, s + 51);
        push_lit(0, 1, 32'h001E_0000, 1'b0, 1'b0, s + 102);
        push_lit(0, 2, 32'h0014_0000, 1'b0, 1'b0, s + 153);
        push_lit(0, 3, 32'h000F_0000, 1'b0, 1'b0, s + 204);
        for (int c = 0; c < 4; c++) begin
            push_model(1, c, 32'(c + 1), s + 51 * (c + 1));
            push_model(2, c, 32'(c + 1), s + 51 * (c + 1));
        end
        wait_drain("allch", 400);

        // ch0 cnt=4: 50 ce cycles capture-to-valid.
        strobe(4'b0001, 32'd4, 32'd0, 32'd0, 32'd0, s);
        push_lit(0, 0, 32'h000F_0000, 1'b0, 1'b0, s + 51);
        push_model(1, 0, 32'd4, s + 51);
        push_model(2, 0, 32'd4, s + 51);
        wait_drain("cnt4", 200);

        // cnt=3: K=2 exercises the floor/round difference.
        strobe(4'b0001, 32'd3, 32'd0, 32'd0, 32'd0, s);
        push_model(0, 0, 32'd3, s + 51);
`ifdef SPEED_COMP_ROUND_EN
        push_lit(1, 0, 32'h0000_AAAB, 1'b0, 1'b0, s + 51);
`else
        push_lit(1, 0, 32'h0000_AAAA, 1'b0, 1'b0, s + 51);
`endif
        push_model(2, 0, 32'd3, s + 51);
        wait_drain("cnt3", 200);

        // Saturation, then zero count with the short path.
        strobe(4'b0100, 32'd0, 32'd0, 32'd1, 32'd0, s);
        push_model(0, 2, 32'd1, s + 51);
        push_model(1, 2, 32'd1, s + 51);
        push_lit(2, 2, 32'h7FFF_FFFF, 1'b1, 1'b0, s + 51);
        wait_drain("sat", 200);
        strobe(4'b0100, 32'd0, 32'd0, 32'd0, 32'd0, s);
        for (int k = 0; k < 3; k++) push_lit(k, 2, 32'h0, 1'b0, 1'b1, s + 3);
        wait_drain("zero", 50);

        // Overrun: ch1 written twice while ch0 divides; the second count wins.
        strobe(4'b0001, 32'd4, 32'd0, 32'd0, 32'd0, s);
        for (int k = 0; k < 3; k++) push_model(k, 0, 32'd4, s + 51);
        push_lit(0, 1, 32'h000F_0000, 1'b0, 1'b0, s + 102);
        push_model(1, 1, 32'd4, s + 102);
        push_model(2, 1, 32'd4, s + 102);
        repeat (3) @(negedge clk);
        strobe(4'b0010, 32'd0, 32'd2, 32'd0, 32'd0, s);
        for (int k = 0; k < 3; k++) chk($sformatf("ovr_after_first_u%0d", k), 64'(ovr[k]), 64'd0);
        repeat (3) @(negedge clk);
        strobe(4'b0010, 32'd0, 32'd4, 32'd0, 32'd0, s);
        for (int k = 0; k < 3; k++) chk($sformatf("ovr_set_u%0d", k), 64'(ovr[k]), 64'h2);
        wait_drain("overrun", 300);
        chk("ovr_sticky_u0", 64'(ovr[0]), 64'h2);
        @(negedge clk);
        overrun_clr = 4'b0010;
        @(negedge clk);
        overrun_clr = 4'b0000;
        for (int k = 0; k < 3; k++) chk($sformatf("ovr_cleared_u%0d", k), 64'(ovr[k]), 64'd0);

        // Reset mid-division with ce toggling; a leftover pending sample must also vanish.
        strobe(4'b1000, 32'd0, 32'd0, 32'd0, 32'd5, s);
        repeat (4) @(negedge clk);
        cnt_valid = 4'b0100;
        speed_cnt = {32'd0, 32'd7, 32'd0, 32'd0};
        @(negedge clk);
        cnt_valid = '0;
        for (int i = 0; i < 16; i++) begin
            ce = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        clr_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(negedge clk);
        ce = 1'b1;
        clr_n = 1'b1;
        @(negedge clk);
        check_reset("postrst");
        repeat (60) @(negedge clk);

        strobe(4'b0010, 32'd0, 32'd3, 32'd0, 32'd0, s);
        for (int k = 0; k < 3; k++) push_model(k, 1, 32'd3, s + 51);
        wait_drain("after_rst", 200);
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/speed_computation_mc.md
# speed_computation_mc

Multi-channel, parametrised successor to the single-channel speed computation block. It converts per-channel period counts (`speed_cnt`, timer ticks per encoder event) into signed fixed-point speed, computed as `floor(K_CONST * 2^OUT_FRAC / cnt)`. All channels share one time-multiplexed radix-2 restoring divider, served round-robin, so no per-channel divider core is needed. It sits between the encoder period counters and the PID controller speed inputs.

## Interface
Parameters:
- `NUM_CH`, 4: number of speed channels (1–16).
- `CNT_WIDTH`, 32: period-count width (unsigned).
- `K_WIDTH`, 32: numerator constant width.
- `K_CONST`, 60000000: numerator (60 s × 1 MHz count clock).
- `OUT_WIDTH`, 32: signed output width.
- `OUT_FRAC`, 16: output fractional bits.

Ports:
- `clk_1` in 1: clock.
- `clr_n_1` in 1: asynchronous reset, active low.
- `ce_1` in 1: clock enable. All state advances only when high.
- `cnt_valid` in NUM_CH: per-channel new-sample strobe.
- `speed_cnt` in NUM_CH*CNT_WIDTH: packed counts; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `speed_rpm` out OUT_WIDTH: result, signed, OUT_FRAC fractional bits.
- `rpm_valid` out 1: result strobe, one ce-qualified cycle.
- `rpm_ch` out clog2(NUM_CH) (min 1): channel of the current result.
- `rpm_sat` out 1: result was saturated.
- `rpm_zero` out 1: input count was 0.
- `overrun` out NUM_CH: sticky per-channel overwrite flag.
- `overrun_clr` in NUM_CH: clears `overrun` bits.

## Operation
- **Pending stage.** Each channel has a pending flag and a count register.
  - `cnt_valid[i]` latches the count and sets pending.
  - If pending is already set, the old sample is overwritten and `overrun[i]` sets.
  - If `overrun_clr[i]` and a new overrun occur in the same cycle, the set wins.
- **IDLE.** If any pending flag is set, pick the lowest-index pending channel strictly after the last-served channel, wrapping. After reset the search starts at channel 0. Clear that channel's pending flag, copy its count into the divider, go to LOAD.
  - If the same channel's `cnt_valid` arrives in the capture cycle, pending stays set with the new sample.
- **LOAD.**
  - Count == 0: go to OUT with `rpm_zero=1` and `speed_rpm=0`.
  - Otherwise: dividend = `K_CONST << OUT_FRAC` (K_WIDTH+OUT_FRAC bits), remainder = 0, iteration counter = K_WIDTH+OUT_FRAC−1. Go to DIV.
- **DIV.** One quotient bit per ce cycle, MSB first.
  - Remainder = {remainder, next dividend bit}.
  - If remainder ≥ count: subtract it and set the quotient bit to 1.
  - Go to OUT when the counter reaches 0.
- **OUT.**
  - If quotient > 2^(OUT_WIDTH−1)−1: output 2^(OUT_WIDTH−1)−1 and set `rpm_sat=1`.
  - Otherwise output the quotient in the low OUT_WIDTH bits.
  - Assert `rpm_valid`, set `rpm_ch`, update last-served, return to IDLE.
- Output values are never negative.
- `speed_rpm`, `rpm_ch`, `rpm_sat` and `rpm_zero` hold their values until the next OUT.

## Timing
- Reset values: FSM=IDLE, all pending=0, `overrun`=0, `speed_rpm`=0, `rpm_valid`=0, `rpm_ch`=0, `rpm_sat`=0, `rpm_zero`=0, last-served=NUM_CH−1.
- Reset takes effect mid-division: the job is discarded, with no partial output.
- Latency, counted in ce cycles from the IDLE capture edge to `rpm_valid`:
  - Nonzero count: 2 + K_WIDTH + OUT_FRAC (default 50).
  - Zero count: 2.
- Sample to capture: at least 1 ce cycle after the `cnt_valid` edge.
- Back-to-back throughput: one result per (3 + K_WIDTH + OUT_FRAC) ce cycles.
- With `ce_1` low, the FSM, pending flags and outputs freeze. `rpm_valid` stays high through a ce-low stall and drops after the next ce-high cycle.
- `cnt_valid` is sampled only when `ce_1` is high.

## Configuration
- `SPEED_COMP_ROUND_EN` defined:
  - Quotient rounds to nearest, adding 1 when 2·remainder ≥ count.
  - Saturation is checked after rounding.
  - OUT adds no cycle; rounding is combinational into the OUT register.
- Undefined: truncation (floor), matching the legacy block.

## Test plan
- K_CONST=60, OUT_FRAC=16, ch0 cnt=4 → `speed_rpm`=0x000F0000, `rpm_ch`=0, `rpm_valid` exactly 50 ce cycles after capture.
- K_CONST=2, cnt=3 → 0x0000AAAA without the macro; 0x0000AAAB with `SPEED_COMP_ROUND_EN`.
- K_CONST=60000, cnt=1 → 0x7FFFFFFF with `rpm_sat`=1. Then cnt=0 → 0x00000000 with `rpm_zero`=1, 2 cycles after capture.
- All 4 channels strobed in the same cycle with counts 1,2,3,4 (K=60) → results in order ch0..ch3: 0x3C0000, 0x1E0000, 0x140000, 0xF0000.
- Ch1 strobed twice while ch0 divides → `overrun[1]`=1 and the second count is used. `overrun_clr[1]` then clears the flag.
- `clr_n_1` low mid-DIV, with `ce_1` toggling 50% → no `rpm_valid`, and all outputs read reset values. After release, a new sample produces a correct result.
